// File: rtl/combine_cb_sequencer_if.sv
// Scheduler, input-buffer read port and combine-datapath output signals of one CB sequencer.
// The master modport is the sequencer side; slave is the scheduler/buffer/datapath side.
interface combine_cb_sequencer_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 48
);
    localparam int LEN_W = ADDR_WIDTH - 2;

    logic                  i_combine_process_request;
    logic [3:0]            i_combine_user_index;
    logic [7:0]            i_pingpong_sel;
    logic [8*LEN_W-1:0]    i_user_cb_len;
    logic                  i_dst_ready;
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic                  o_out_valid;
    logic                  o_out_last;
    logic [DATA_WIDTH-1:0] o_out_data;
    logic [2:0]            o_out_user;
    logic                  o_current_cb_combine_comp;
    logic                  o_busy;
    logic                  o_err_invalid_user;

    modport master (
        input  i_combine_process_request, i_combine_user_index, i_pingpong_sel,
               i_user_cb_len, i_dst_ready, i_rd_data,
        output o_rd_en, o_rd_addr, o_out_valid, o_out_last, o_out_data, o_out_user,
               o_current_cb_combine_comp, o_busy, o_err_invalid_user
    );

    modport slave (
        output i_combine_process_request, i_combine_user_index, i_pingpong_sel,
               i_user_cb_len, i_dst_ready, i_rd_data,
        input  o_rd_en, o_rd_addr, o_out_valid, o_out_last, o_out_data, o_out_user,
               o_current_cb_combine_comp, o_busy, o_err_invalid_user
    );
endinterface

// File: rtl/combine_cb_sequencer.sv
// Runs one code-block combine job: latches user/bank/length, streams the CB out of the
// input buffer with a latency-matched tag pipeline, then pulses completion to the scheduler.
module combine_cb_sequencer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 48,
    parameter int RD_LAT     = 2
) (
    input  logic                   i_core_clk,
    input  logic                   i_rx_rstn,
    input  logic                   i_rx_fsm_rstn,
    combine_cb_sequencer_if.master bus
);
    localparam int OFF_W = ADDR_WIDTH - 4;
    localparam int LEN_W = ADDR_WIDTH - 2;
    localparam logic [LEN_W-1:0] REGION_LEN = LEN_W'(2 ** OFF_W);

    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE, WAIT_LOW} state_t;

    state_t                      r_state;
    logic [2:0]                  r_user;
    logic                        r_user_ok;
    logic                        r_bank;
    logic [LEN_W-1:0]            r_len_raw;
    logic [OFF_W-1:0]            r_offset;
    logic                        r_pending;
    logic                        r_comp;
    logic                        r_busy;
    logic                        r_err;
    logic [RD_LAT-1:0]           r_pv;
    logic [RD_LAT-1:0]           r_pl;
    logic [RD_LAT-1:0][2:0]      r_pu;
    logic                        r_out_valid;
    logic                        r_out_last;
    logic [DATA_WIDTH-1:0]       r_out_data;
    logic [2:0]                  r_out_user;

    logic [OFF_W:0]              w_len_eff;
    logic                        w_last;
    logic                        w_rd_en;

    assign w_len_eff = (r_len_raw > REGION_LEN) ? REGION_LEN[OFF_W:0] : r_len_raw[OFF_W:0];
    assign w_last    = ({1'b0, r_offset} == w_len_eff - (OFF_W + 1)'(1));
    assign w_rd_en   = (r_state == READ) && bus.i_dst_ready;

    assign bus.o_rd_en                   = w_rd_en;
    assign bus.o_rd_addr                 = {r_bank, r_user, r_offset};
    assign bus.o_out_valid               = r_out_valid;
    assign bus.o_out_last                = r_out_last;
    assign bus.o_out_data                = r_out_data;
    assign bus.o_out_user                = r_out_user;
    assign bus.o_current_cb_combine_comp = r_comp;
    assign bus.o_busy                    = r_busy;
    assign bus.o_err_invalid_user        = r_err;

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            r_state     <= IDLE;
            r_user      <= '0;
            r_user_ok   <= 1'b0;
            r_bank      <= 1'b0;
            r_len_raw   <= '0;
            r_offset    <= '0;
            r_pending   <= 1'b0;
            r_comp      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_pv        <= '0;
            r_pl        <= '0;
            r_pu        <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_user  <= '0;
        end else if (!i_rx_fsm_rstn) begin
            r_state     <= IDLE;
            r_user      <= '0;
            r_user_ok   <= 1'b0;
            r_bank      <= 1'b0;
            r_len_raw   <= '0;
            r_offset    <= '0;
            r_pending   <= 1'b0;
            r_comp      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_pv        <= '0;
            r_pl        <= '0;
            r_pu        <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_user  <= '0;
        end else begin
            // Tags travel alongside the buffer latency so they meet i_rd_data in the last stage.
            r_pv[0] <= w_rd_en;
            r_pl[0] <= w_rd_en & w_last;
            r_pu[0] <= r_user;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pl[i] <= r_pl[i-1];
                r_pu[i] <= r_pu[i-1];
            end
            r_out_valid <= r_pv[RD_LAT-1];
            r_out_last  <= r_pv[RD_LAT-1] & r_pl[RD_LAT-1];
            if (r_pv[RD_LAT-1]) begin
                r_out_data <= bus.i_rd_data;
                r_out_user <= r_pu[RD_LAT-1];
            end

            case (r_state)
                IDLE: begin
                    if (bus.i_combine_process_request) begin
                        r_state   <= LOAD;
                        r_busy    <= 1'b1;
                        r_user    <= bus.i_combine_user_index[2:0];
                        r_user_ok <= ~bus.i_combine_user_index[3];
                        r_bank    <= bus.i_pingpong_sel[bus.i_combine_user_index[2:0]];
                        r_len_raw <= bus.i_user_cb_len[bus.i_combine_user_index[2:0]*LEN_W +: LEN_W];
                    end
                end
                LOAD: begin
                    r_offset <= '0;
                    // Empty jobs pass through DRAIN with nothing pending, which lands the
                    // completion pulse three cycles after the request was taken.
                    if (!r_user_ok || w_len_eff == '0) begin
                        r_pending <= 1'b0;
                        r_state   <= DRAIN;
                        if (!r_user_ok) r_err <= 1'b1;
                    end else begin
                        r_pending <= 1'b1;
                        r_state   <= READ;
                    end
                end
                READ: begin
                    if (w_rd_en) begin
                        r_offset <= r_offset + 1'b1;
                        if (w_last) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!r_pending || r_out_last) begin
                        r_pending <= 1'b0;
                        r_comp    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_comp  <= 1'b0;
                    r_state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!bus.i_combine_process_request) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
